div_req_sequencer: RTL and testbench
====================================

// Module: div_req_sequencer
// PURPOSE
//  Request front-end and result back-end for the restoring divider (Div).
//  Buffers divide requests in a small FIFO and loads each into Div: drives
//  operands, holds Div's reset for 2 cycles, then waits for its done flag.
//  Captures quotient/remainder and presents them on a valid/ready result port.
//  Divide-by-zero is resolved locally; Div is never launched with a zero divisor.
// PARAMETERS
//  L        16    dividend / quotient width; remainder width is L+1
//  l        3     divisor width
//  DEPTH    4     request FIFO entries (power of 2, >=2)
//  TIMEOUT  40    max RUN cycles before abort (used only with DIV_SEQ_TIMEOUT_EN)
// PORTS
//  Clk            in   1      clock, rising edge
//  Rst            in   1      asynchronous, active-high reset
//  req_valid      in   1      request offered
//  req_ready      out  1      request FIFO not full
//  req_dividend   in   L      dividend
//  req_divisor    in   l      divisor
//  res_valid      out  1      result held for consumer
//  res_ready      in   1      consumer accepts result
//  res_quotient   out  L      quotient
//  res_remainder  out  L+1    remainder
//  res_err        out  1      1 = divide-by-zero or timeout
//  div_dividend   out  L      to Div Dividend
//  div_divisor    out  l      to Div Divisor
//  div_rst        out  1      to Div Rst (load/restart)
//  div_state      in   1      from Div State; 1 = division complete
//  div_q          in   L      from Div Q
//  div_a          in   L+1    from Div A
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, req_ready=1, res_valid=0, res_err=0,
//   res_quotient=0, res_remainder=0, div_dividend=0, div_divisor=0, div_rst=1.
//  FIFO: push on req_valid&req_ready; req_ready = !full (a pop in the same cycle
//   does not free a slot for that cycle's push); pointers wrap mod DEPTH.
//  FSM states: IDLE, LOAD, RUN, OUT.
//   IDLE: div_rst=1. If FIFO non-empty: pop head.
//    divisor==0 -> res_quotient={L{1}}, res_remainder={1'b0,dividend},
//     res_err=1, go OUT (Div not launched).
//    else latch operands onto div_dividend/div_divisor, go LOAD.
//   LOAD: div_rst=1 for exactly 2 cycles with stable operands, then RUN.
//   RUN: div_rst=0; operands held stable. First cycle div_state sampled 1:
//    res_quotient<=div_q, res_remainder<=div_a, res_err<=0, go OUT.
//   OUT: res_valid=1; outputs stable until res_ready. On res_valid&res_ready:
//    res_valid=0 next cycle, back to IDLE, div_rst=1.
//  Only one division in flight; FIFO accepts requests during LOAD/RUN/OUT.
//  Result order equals request order.
//  Rst mid-operation: in-flight and queued requests discarded; no result emitted.
//  div_state high while in IDLE/LOAD/OUT is ignored.
// CONFIGURATION
//  DIV_SEQ_TIMEOUT_EN defined: RUN counter clears on entering RUN; if it reaches
//   TIMEOUT with div_state still 0 -> res_quotient=0, res_remainder=0,
//   res_err=1, go OUT (div_rst reasserts from IDLE on).
//  Not defined: no counter; RUN waits for div_state indefinitely.
// TESTING
//  36/7 -> res_quotient=5, res_remainder=1, res_err=0; div_rst high exactly 2 cycles
//  781/6 then 463/5 pushed back-to-back -> results 130 r1 then 92 r3, in order
//  dividend=100, divisor=0 -> Q=16'hFFFF, rem=100, err=1; div_rst never deasserts
//  res_ready=0; push DEPTH+2 requests -> req_ready drops after DEPTH accepted
//   (1 in flight); all results later drained in order, none lost
//  Rst pulsed during RUN -> res_valid=0, FIFO empty, div_rst=1; next 36/7 gives 5 r1
//  TIMEOUT_EN, div_state tied 0 -> res_valid with err=1 after TIMEOUT RUN cycles

Source files
------------

// File: rtl/div_req_sequencer.sv
// div_req_sequencer: request FIFO and launch/capture sequencer around the restoring divider.
// Optional DIV_SEQ_TIMEOUT_EN aborts a run that exceeds TIMEOUT cycles.
module div_req_sequencer #(
  parameter int L       = 16,
  parameter int l       = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [L-1:0] req_dividend_i,
  input  logic [l-1:0] req_divisor_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [L-1:0] res_quotient_o,
  output logic [L:0]   res_remainder_o,
  output logic         res_err_o,
  output logic [L-1:0] div_dividend_o,
  output logic [l-1:0] div_divisor_o,
  output logic         div_rst_o,
  input  logic         div_state_i,
  input  logic [L-1:0] div_q_i,
  input  logic [L:0]   div_a_i
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_e;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("div_req_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end
  state_e         state_q, state_d;
  logic [L+l-1:0] mem_q [DEPTH];
  logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
  logic           full, empty, push, pop, head_zero, timeout;
  logic [L-1:0]   head_dvd;
  logic [l-1:0]   head_dvs;
  logic           ld_q, ld_d, err_q, err_d;
  logic [L-1:0]   q_q, q_d, dvd_q, dvd_d;
  logic [L:0]     r_q, r_d;
  logic [l-1:0]   dvs_q, dvs_d;
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full      = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign empty     = wr_q == rd_q;
  assign push      = req_valid_i & ~full;
  assign pop       = state_q == IDLE & ~empty;
  assign {head_dvd, head_dvs} = mem_q[rd_q[AW-1:0]];
  assign head_zero = head_dvs == '0;
  assign wr_d      = wr_q + (AW+1)'(push);
  assign rd_d      = rd_q + (AW+1)'(pop);
`ifdef DIV_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  assign timeout = tmo_q == TW'(TIMEOUT - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= state_q == RUN ? tmo_q + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_q[AW-1:0]] <= {req_dividend_i, req_divisor_i};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = empty ? IDLE : head_zero ? OUT : LOAD;
      LOAD:    state_d = ld_q ? RUN : LOAD;
      RUN:     state_d = (div_state_i | timeout) ? OUT : RUN;
      default: state_d = res_ready_i ? IDLE : OUT;
    endcase
  end
  always_comb begin
    ld_d  = state_q == LOAD & ~ld_q;
    dvd_d = pop & ~head_zero ? head_dvd : dvd_q;
    dvs_d = pop & ~head_zero ? head_dvs : dvs_q;
    q_d   = q_q;
    r_d   = r_q;
    err_d = err_q;
    if (pop & head_zero) begin
      q_d   = '1;
      r_d   = {1'b0, head_dvd};
      err_d = 1'b1;
    end else if (state_q == RUN & div_state_i) begin
      q_d   = div_q_i;
      r_d   = div_a_i;
      err_d = 1'b0;
    end else if (state_q == RUN & timeout) begin
      q_d   = '0;
      r_d   = '0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ld_q  <= 1'b0;
      q_q   <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
      dvd_q <= '0;
      dvs_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ld_q  <= ld_d;
      q_q   <= q_d;
      r_q   <= r_d;
      err_q <= err_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
    end
  always_comb begin
    req_ready_o     = ~full;
    res_valid_o     = state_q == OUT;
    div_rst_o       = state_q != RUN;
    res_quotient_o  = q_q;
    res_remainder_o = r_q;
    res_err_o       = err_q;
    div_dividend_o  = dvd_q;
    div_divisor_o   = dvs_q;
  end
endmodule

// File: tb/tb_div_req_sequencer.sv
// tb_div_req_sequencer: directed and random checks of div_req_sequencer against a queue-based model.
module tb_div_req_sequencer;
  localparam int L = 16, LW = 3, DEPTH = 4, TIMEOUT = 40;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, res_valid, res_ready = 1'b0, res_err;
  logic [L-1:0] req_dividend = '0, res_quotient, div_dividend, div_q;
  logic [LW-1:0] req_divisor = '0, div_divisor;
  logic [L:0] res_remainder, div_a;
  logic div_rst, div_state;
  typedef struct {logic [L-1:0] q; logic [L:0] r; logic e;} res_t;
  res_t exp_q[$];
  int checks = 0, errors = 0;
  int lat_q = 0;
  logic glitch_q = 1'b0, tie0 = 1'b0;
  always #5 clk = ~clk;
  div_req_sequencer #(.L(L), .l(LW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dividend_i(req_dividend), .req_divisor_i(req_divisor),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_quotient_o(res_quotient),
    .res_remainder_o(res_remainder), .res_err_o(res_err),
    .div_dividend_o(div_dividend), .div_divisor_o(div_divisor), .div_rst_o(div_rst),
    .div_state_i(div_state), .div_q_i(div_q), .div_a_i(div_a));
  // Divider stand-in: random latency after release, random junk while held in reset.
  always @(posedge clk) begin
    glitch_q <= 1'($urandom);
    if (div_rst) lat_q <= $urandom_range(L, 0);
    else if (lat_q > 0) lat_q <= lat_q - 1;
  end
  assign div_state = tie0 ? 1'b0 : div_rst ? glitch_q : lat_q == 0;
  assign div_q = (div_rst || lat_q != 0 || div_divisor == 0) ? 16'hA5A5 : div_dividend / L'(div_divisor);
  assign div_a = (div_rst || lat_q != 0 || div_divisor == 0) ? 17'h15A5A : {1'b0, div_dividend % L'(div_divisor)};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic res_t model(input int dvd, input int dvs);
    res_t t;
    if (dvs == 0) begin
      t.q = '1; t.r = 17'(dvd); t.e = 1'b1;
    end else begin
      t.q = 16'(dvd / dvs); t.r = 17'(dvd % dvs); t.e = 1'b0;
    end
    return t;
  endfunction
  // Called at a negedge: score the handshakes about to happen, then advance one cycle.
  task automatic step();
    res_t t;
    if (res_valid && res_ready) begin
      chk("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        chk("quotient", res_quotient, t.q);
        chk("remainder", res_remainder, t.r);
        chk("err", res_err, t.e);
      end
    end
    if (req_valid && req_ready) exp_q.push_back(model(req_dividend, req_divisor));
    @(negedge clk);
  endtask
  task automatic push_req(input int dvd, input int dvs);
    logic acc = 1'b0;
    req_valid = 1'b1; req_dividend = 16'(dvd); req_divisor = 3'(dvs);
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = req_ready;
      step();
    end
    req_valid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask
  task automatic drain(input bit rnd);
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) begin
      res_ready = rnd ? 1'($urandom) : 1'b1;
      step();
    end
    res_ready = 1'b0;
    chk("drained", exp_q.size(), 0);
  endtask
  task automatic hold_check();
    res_ready = 1'b0;
    for (int i = 0; i < 100 && !res_valid; i++) step();
    chk("res_valid_up", res_valid, 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_quotient", res_quotient, exp_q[0].q);
      chk("hold_remainder", res_remainder, exp_q[0].r);
      step();
    end
  endtask
  initial begin
    int n, acc;
    logic low_seen;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_quotient", res_quotient, 0);
    chk("rst_remainder", res_remainder, 0);
    chk("rst_div_dividend", div_dividend, 0);
    chk("rst_div_divisor", div_divisor, 0);
    chk("rst_div_rst", div_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    push_req(36, 7);
    n = 0;
    for (int i = 0; i < 10 && div_rst; i++) begin
      if (div_divisor == 7 && div_dividend == 36) n++;
      step();
    end
    chk("load_cycles", n, 2);
    hold_check();
    drain(0);
    push_req(781, 6);
    push_req(463, 5);
    drain(1);
    res_ready = 1'b0;
    push_req(100, 0);
    low_seen = 1'b0;
    for (int i = 0; i < 20 && !res_valid; i++) begin
      if (!div_rst) low_seen = 1'b1;
      step();
    end
    chk("div0_no_launch", low_seen, 0);
    hold_check();
    drain(0);
    acc = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 30 && req_ready; i++) begin
      req_dividend = 16'($urandom); req_divisor = 3'($urandom_range(7, 0));
      acc++;
      step();
    end
    req_valid = 1'b0;
    chk("accepted_before_full", acc, DEPTH + 1);
    step();
    chk("stays_full", req_ready, 0);
    drain(1);
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom); res_ready = 1'($urandom);
      req_dividend = 16'($urandom); req_divisor = 3'($urandom_range(7, 0));
      step();
    end
    req_valid = 1'b0;
    drain(1);
    tie0 = 1'b1;
    push_req(36, 7);
    for (int i = 0; i < 10 && div_rst; i++) step();
    chk("run_entered", div_rst, 0);
    push_req(50, 3);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_div_rst", div_rst, 1);
    @(negedge clk);
    rst = 1'b0; tie0 = 1'b0; res_ready = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid || !div_rst) low_seen = 1'b1;
      step();
    end
    chk("no_result_after_rst", low_seen, 0);
    push_req(36, 7);
    drain(0);
`ifdef DIV_SEQ_TIMEOUT_EN
    tie0 = 1'b1;
    push_req(36, 7);
    exp_q[$].q = '0; exp_q[$].r = '0; exp_q[$].e = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && !res_valid; i++) begin
      if (!div_rst) n++;
      step();
    end
    chk("timeout_cycles", n, TIMEOUT);
    drain(0);
    tie0 = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
